// File: rtl/abacbd_aoi.sv
// abacbd_aoi: registered AND-OR-INVERT cell, f = ~(a&b | a&c | b&d).
//
// This is the synthesizable model of the abacbd CMOS complex gate. The
// unregistered result is exposed on f_comb for static timing and for
// equivalence checks against the transistor-level gate. The registered
// result f is loaded only on edges where in_valid is high.
//
// Ports:
//   clk       in   rising-edge clock for all state
//   rst_n     in   asynchronous active-low reset (f=1, out_valid=0)
//   a,b,c,d   in   single-bit operands
//   in_valid  in   qualifies a/b/c/d at the current clk edge
//   f_comb    out  combinational ~(a&b | a&c | b&d), ignores clk/rst_n/in_valid
//   f         out  registered result, holds when in_valid=0
//   out_valid out  high for one cycle after f was loaded from a valid sample
module abacbd_aoi (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic in_valid,
    output logic f_comb,
    output logic f,
    output logic out_valid
);

    logic f_q;
    logic f_d;
    logic vld_q;
    logic vld_d;

    // Combinational stage: plain operators so X/Z propagate naturally.
    assign f_comb = ~((a & b) | (a & c) | (b & d));

    always_comb begin
        f_d   = f_q;
        vld_d = in_valid;
        if (in_valid) begin
            f_d = f_comb;
        end
    end

    // Register stage: reset value 1 equals the function value for abcd=0000.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q   <= 1'b1;
            vld_q <= 1'b0;
        end else begin
            f_q   <= f_d;
            vld_q <= vld_d;
        end
    end

    assign f         = f_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_abacbd_aoi.sv
module tb_abacbd_aoi;

    logic clk;
    logic rst_n;
    logic a, b, c, d;
    logic in_valid;
    logic f_comb, f, out_valid;

    int errors;
    int checks;

    // Reference state for the registered outputs.
    logic exp_f;
    logic exp_vld;

    abacbd_aoi dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .in_valid (in_valid),
        .f_comb   (f_comb),
        .f        (f),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Function defined by its zero set: abcd codes (a = MSB) that give 0.
    function automatic logic ref_func(input logic [3:0] code);
        int zeros[8] = '{5, 7, 10, 11, 12, 13, 14, 15};
        ref_func = 1'b1;
        foreach (zeros[i]) begin
            if (int'(code) == zeros[i]) ref_func = 1'b0;
        end
    endfunction

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Apply one sample just after a rising edge, check f_comb, then step to
    // the next edge and check the registered outputs against the model.
    task automatic step(input logic [3:0] code, input logic v, input string tag);
        {a, b, c, d} = code;
        in_valid = v;
        #1;
        check({tag, ":f_comb"}, f_comb, ref_func(code));
        @(posedge clk);
        if (v) exp_f = ref_func(code);
        exp_vld = v;
        #1;
        check({tag, ":f"}, f, exp_f);
        check({tag, ":out_valid"}, out_valid, exp_vld);
    endtask

    initial begin
        logic [15:0] sweep_exp;
        logic        prev_f;
        logic [3:0]  r;

        errors   = 0;
        checks   = 0;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        {a, b, c, d} = 4'b1011;
        exp_f    = 1'b1;
        exp_vld  = 1'b0;

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async:f", f, 1'b1);
        check("reset_async:out_valid", out_valid, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(4'($urandom_range(15)), 1'b0, "post_reset_idle");

        // Exhaustive ascending sweep, checked against the literal sequence.
        sweep_exp = 16'b1111101011000000;
        prev_f = 1'b1;
        for (int i = 0; i < 16; i++) begin
            {a, b, c, d} = 4'(i);
            in_valid = 1'b1;
            #1;
            check("sweep:f_comb", f_comb, sweep_exp[15-i]);
            check("sweep:f_prev", f, prev_f);
            @(posedge clk);
            #1;
            check("sweep:f", f, sweep_exp[15-i]);
            check("sweep:out_valid", out_valid, 1'b1);
            prev_f = sweep_exp[15-i];
        end
        exp_f = prev_f;
        exp_vld = 1'b1;

        // Term isolation.
        step(4'b1100, 1'b1, "term_ab");
        check("term_ab:val", f, 1'b0);
        step(4'b1010, 1'b1, "term_ac");
        check("term_ac:val", f, 1'b0);
        step(4'b0101, 1'b1, "term_bd");
        check("term_bd:val", f, 1'b0);
        step(4'b1001, 1'b1, "term_1001");
        check("term_1001:val", f, 1'b1);
        step(4'b0110, 1'b1, "term_0110");
        check("term_0110:val", f, 1'b1);

        // Hold: capture 1111 then idle with inputs at 0000.
        step(4'b1111, 1'b1, "hold_capture");
        for (int i = 0; i < 4; i++) begin
            step(4'b0000, 1'b0, "hold");
            check("hold:f_held", f, 1'b0);
            check("hold:f_comb_one", f_comb, 1'b1);
        end

        // Random stimulus against the model.
        for (int i = 0; i < 60; i++) begin
            r = 4'($urandom_range(15));
            step(r, 1'($urandom_range(1)), "random");
        end

        // Mid-stream reset during back-to-back valid samples.
        step(4'b1111, 1'b1, "mid_pre0");
        step(4'b1110, 1'b1, "mid_pre1");
        {a, b, c, d} = 4'b1101;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset:f", f, 1'b1);
        check("mid_reset:out_valid", out_valid, 1'b0);
        check("mid_reset:f_comb", f_comb, 1'b0);
        @(posedge clk);
        #1;
        check("mid_reset_edge:f", f, 1'b1);
        check("mid_reset_edge:out_valid", out_valid, 1'b0);
        #2;
        rst_n = 1'b1;
        exp_f = 1'b1;
        exp_vld = 1'b0;
        @(posedge clk);
        #1;
        exp_f = ref_func(4'b1101);
        exp_vld = 1'b1;
        check("after_release:f", f, exp_f);
        step(4'b0111, 1'b1, "after_reset_0111");
        check("after_reset_0111:val", f, 1'b0);
        step(4'b0000, 1'b0, "tail");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
